// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: shared state enum, packet byte-0 bit positions, screen defaults and delta helper.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} ps2_state_e;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_MIDDLE = 2;
    localparam int SYNC_BIT   = 3;
    localparam int SIGN_X     = 4;
    localparam int SIGN_Y     = 5;
    localparam int OVF_X      = 6;
    localparam int OVF_Y      = 7;

    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;
    localparam int DEF_TIMEOUT  = 50000;

    // 9-bit two's-complement movement widened to 12 bits; an overflowed axis contributes nothing
    function automatic logic signed [11:0] delta_of(input logic sign, input logic ovf, input logic [7:0] mag);
        return ovf ? 12'sd0 : $signed({{4{sign}}, mag});
    endfunction

endpackage

// File: rtl/ps2_mouse_axis_clamp.sv
// ps2_mouse_axis_clamp: one cursor axis, signed add of a movement with saturation to 0..LIMIT-1.
module ps2_mouse_axis_clamp
    import ps2_mouse_pkg::*;
#(
    parameter int W     = 10,
    parameter int LIMIT = DEF_SCREEN_W
) (
    input  logic [W-1:0]        pos,
    input  logic signed [11:0]  delta,
    output logic [W-1:0]        result
);

    localparam logic signed [11:0] MAX = 12'(LIMIT - 1);

    logic signed [11:0] sum;

    assign sum    = $signed(12'(pos)) + delta;
    assign result = (sum < 12'sd0) ? '0 : (sum > MAX) ? W'(MAX) : sum[W-1:0];

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder: frames 3-byte PS/2 mouse packets into a clamped cursor position and buttons.
// Define PS2_MOUSE_SYNC_CHECK_EN to reject byte-0 candidates whose always-one bit 3 is clear.
module ps2_mouse_packet_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int SCREEN_W       = DEF_SCREEN_W,
    parameter int SCREEN_H       = DEF_SCREEN_H,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       clear_position,
    output logic [9:0] x_pos,
    output logic [8:0] y_pos,
    output logic       left_button,
    output logic       right_button,
    output logic       middle_button,
    output logic       mousePressed,
    output logic       packet_valid,
    output logic       packet_error
);

    localparam int         CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [9:0] X_MID = 10'(SCREEN_W / 2);
    localparam logic [8:0] Y_MID = 9'(SCREEN_H / 2);

    ps2_state_e state, state_d;
    logic          en_q, acc_q, sync_ok, timeout, sync_err, upd, take_b0;
    logic [7:0]    data_q, b0, b1, b2;
    logic [CW-1:0] cnt, cnt_d;
    logic [9:0]    new_x;
    logic [8:0]    new_y;

`ifdef PS2_MOUSE_SYNC_CHECK_EN
    assign sync_ok = data_q[SYNC_BIT];
`else
    assign sync_ok = 1'b1;
`endif

    assign upd     = state == UPDATE;
    // A byte arriving during UPDATE is already the next packet's byte 0
    assign take_b0 = acc_q && sync_ok && (state == WAIT_B0 || upd);

    always_comb begin
        state_d  = state;
        cnt_d    = '0;
        timeout  = 1'b0;
        sync_err = 1'b0;
        case (state)
            WAIT_B0, UPDATE: begin
                state_d  = (acc_q && sync_ok) ? WAIT_B1 : WAIT_B0;
                sync_err = acc_q && !sync_ok;
            end
            WAIT_B1, WAIT_B2: begin
                timeout = !acc_q && cnt == CW'(TIMEOUT_CYCLES);
                cnt_d   = (acc_q || timeout) ? '0 : cnt + 1'b1;
                state_d = timeout ? WAIT_B0 : !acc_q ? state : (state == WAIT_B1) ? WAIT_B2 : UPDATE;
            end
            default: state_d = WAIT_B0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= WAIT_B0;
            cnt           <= '0;
            en_q          <= 1'b0;
            acc_q         <= 1'b0;
            data_q        <= '0;
            b0            <= '0;
            b1            <= '0;
            b2            <= '0;
            x_pos         <= X_MID;
            y_pos         <= Y_MID;
            left_button   <= 1'b0;
            right_button  <= 1'b0;
            middle_button <= 1'b0;
            mousePressed  <= 1'b0;
            packet_valid  <= 1'b0;
            packet_error  <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            en_q   <= received_data_en;
            acc_q  <= received_data_en & ~en_q;
            if (received_data_en & ~en_q)
                data_q <= received_data;
            if (take_b0)
                b0 <= data_q;
            if (acc_q && state == WAIT_B1)
                b1 <= data_q;
            if (acc_q && state == WAIT_B2)
                b2 <= data_q;
            packet_valid <= upd;
            packet_error <= timeout | sync_err;
            mousePressed <= upd & b0[BTN_LEFT] & ~left_button;
            if (upd) begin
                left_button   <= b0[BTN_LEFT];
                right_button  <= b0[BTN_RIGHT];
                middle_button <= b0[BTN_MIDDLE];
            end
            if (clear_position) begin
                x_pos <= X_MID;
                y_pos <= Y_MID;
            end else if (upd) begin
                x_pos <= new_x;
                y_pos <= new_y;
            end
        end
    end

    ps2_mouse_axis_clamp #(.W(10), .LIMIT(SCREEN_W)) u_clamp_x (
        .pos    (x_pos),
        .delta  (delta_of(b0[SIGN_X], b0[OVF_X], b1)),
        .result (new_x)
    );

    // Screen Y grows downward while PS/2 +Y means up
    ps2_mouse_axis_clamp #(.W(9), .LIMIT(SCREEN_H)) u_clamp_y (
        .pos    (y_pos),
        .delta  (-delta_of(b0[SIGN_Y], b0[OVF_Y], b2)),
        .result (new_y)
    );

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// tb_ps2_mouse_packet_decoder: packet table plus timeout, clear, reset and sync sequences, scoreboard-checked.
module tb_ps2_mouse_packet_decoder;

    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] received_data = '0;
    logic       received_data_en = 1'b0;
    logic       clear_position = 1'b0;
    logic [9:0] x_pos;
    logic [8:0] y_pos;
    logic       left_button, right_button, middle_button;
    logic       mousePressed, packet_valid, packet_error;

    ps2_mouse_packet_decoder #(.SCREEN_W(320), .SCREEN_H(240), .TIMEOUT_CYCLES(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .clear_position   (clear_position),
        .x_pos            (x_pos),
        .y_pos            (y_pos),
        .left_button      (left_button),
        .right_button     (right_button),
        .middle_button    (middle_button),
        .mousePressed     (mousePressed),
        .packet_valid     (packet_valid),
        .packet_error     (packet_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] btn;
        logic       pr;
    } exp_t;

    typedef struct {
        bit         rst;
        int         hold;
        logic [7:0] b0, b1, b2;
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] btn;
        logic       pr;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vec[17];
    int   errors = 0, checks = 0;
    int   valid_cnt = 0, err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (packet_error) err_cnt++;
        if (mousePressed && !packet_valid) begin
            checks++;
            errors++;
            $display("FAIL pressed_alone: mousePressed=1 without packet_valid at %0t", $time);
        end
        if (packet_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: packet_valid=1 with no packet expected at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("x_pos", 32'(x_pos), 32'(mon_e.x));
                check("y_pos", 32'(y_pos), 32'(mon_e.y));
                check("buttons", 32'({middle_button, right_button, left_button}), 32'(mon_e.btn));
                check("mousePressed", 32'(mousePressed), 32'(mon_e.pr));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk); #1;
        received_data    = b;
        received_data_en = 1'b1;
        repeat (hold) @(posedge clk);
        #1 received_data_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d packets outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_packet(input logic [7:0] b0, b1, b2, input int hold,
                              input logic [9:0] x, input logic [8:0] y, input logic [2:0] btn, input logic pr);
        sb.push_back('{x, y, btn, pr});
        send_byte(b0, hold);
        send_byte(b1, hold);
        send_byte(b2, hold);
        wait_drain();
    endtask

    task automatic do_reset();
        received_data_en = 1'b0;
        clear_position   = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_position = 1'b1;
        @(posedge clk); #1 clear_position = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, n;
        vec[0]  = '{1'b0, 1, 8'h08, 8'h10, 8'h05, 10'd176, 9'd115, 3'b000, 1'b0};
        vec[1]  = '{1'b1, 1, 8'h19, 8'hC0, 8'h00, 10'd96,  9'd120, 3'b001, 1'b1};
        vec[2]  = '{1'b0, 1, 8'h19, 8'hC0, 8'h00, 10'd32,  9'd120, 3'b001, 1'b0};
        vec[3]  = '{1'b0, 1, 8'h19, 8'hC0, 8'h00, 10'd0,   9'd120, 3'b001, 1'b0};
        vec[4]  = '{1'b0, 1, 8'h08, 8'h00, 8'h00, 10'd0,   9'd120, 3'b000, 1'b0};
        vec[5]  = '{1'b0, 1, 8'h09, 8'h00, 8'h00, 10'd0,   9'd120, 3'b001, 1'b1};
        vec[6]  = '{1'b0, 1, 8'h09, 8'h00, 8'h00, 10'd0,   9'd120, 3'b001, 1'b0};
        vec[7]  = '{1'b0, 1, 8'h48, 8'h7F, 8'h00, 10'd0,   9'd120, 3'b000, 1'b0};
        vec[8]  = '{1'b0, 1, 8'h28, 8'h00, 8'h80, 10'd0,   9'd239, 3'b000, 1'b0};
        vec[9]  = '{1'b0, 1, 8'h08, 8'h00, 8'h7F, 10'd0,   9'd112, 3'b000, 1'b0};
        vec[10] = '{1'b0, 1, 8'h88, 8'h05, 8'h50, 10'd5,   9'd112, 3'b000, 1'b0};
        vec[11] = '{1'b0, 1, 8'h08, 8'hFF, 8'h00, 10'd260, 9'd112, 3'b000, 1'b0};
        vec[12] = '{1'b0, 1, 8'h08, 8'hFF, 8'h00, 10'd319, 9'd112, 3'b000, 1'b0};
        vec[13] = '{1'b0, 1, 8'h0E, 8'h00, 8'h00, 10'd319, 9'd112, 3'b110, 1'b0};
        vec[14] = '{1'b0, 1, 8'h09, 8'h01, 8'h01, 10'd319, 9'd111, 3'b001, 1'b1};
        vec[15] = '{1'b0, 5, 8'h18, 8'hFF, 8'h00, 10'd318, 9'd111, 3'b000, 1'b0};
        vec[16] = '{1'b0, 5, 8'h39, 8'h02, 8'hFE, 10'd64,  9'd113, 3'b001, 1'b1};

        do_reset();
        @(negedge clk);
        check("reset_x", 32'(x_pos), 32'd160);
        check("reset_y", 32'(y_pos), 32'd120);
        check("reset_buttons", 32'({middle_button, right_button, left_button}), 32'd0);
        check("reset_pulses", 32'({mousePressed, packet_valid, packet_error}), 32'd0);

        for (int i = 0; i < 17; i++) begin
            if (vec[i].rst) do_reset();
            run_packet(vec[i].b0, vec[i].b1, vec[i].b2, vec[i].hold, vec[i].x, vec[i].y, vec[i].btn, vec[i].pr);
        end
        check("valid_count_table", 32'(valid_cnt), 32'd17);
        check("no_error_table", 32'(err_cnt), 32'd0);

        v0 = valid_cnt;
        e0 = err_cnt;
        send_byte(8'h08, 1);
        send_byte(8'h10, 1);
        n = 0;
        while (err_cnt == e0 && n < TMO + 50) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("timeout_error_pulses", 32'(err_cnt - e0), 32'd1);
        check("timeout_x_held", 32'(x_pos), 32'd64);
        check("timeout_y_held", 32'(y_pos), 32'd113);
        check("timeout_buttons_held", 32'({middle_button, right_button, left_button}), 32'b001);
        check("timeout_no_valid", 32'(valid_cnt - v0), 32'd0);
        run_packet(8'h08, 8'h01, 8'h01, 1, 10'd65, 9'd112, 3'b000, 1'b0);

        sb.push_back('{10'd160, 9'd120, 3'b000, 1'b0});
        send_byte(8'h08, 1);
        send_byte(8'h05, 1);
        @(posedge clk); #1;
        received_data    = 8'h05;
        received_data_en = 1'b1;
        @(posedge clk); #1 received_data_en = 1'b0;
        @(posedge clk); #1 clear_position = 1'b1;
        @(posedge clk); #1 clear_position = 1'b0;
        wait_drain();

        run_packet(8'h08, 8'h07, 8'h00, 1, 10'd167, 9'd120, 3'b000, 1'b0);
        v0 = valid_cnt;
        sb.push_back('{10'd163, 9'd120, 3'b000, 1'b0});
        send_byte(8'h08, 1);
        pulse_clear();
        check("clear_x", 32'(x_pos), 32'd160);
        check("clear_y", 32'(y_pos), 32'd120);
        send_byte(8'h03, 1);
        send_byte(8'h00, 1);
        wait_drain();
        check("clear_framing_valid", 32'(valid_cnt - v0), 32'd1);

        send_byte(8'h08, 1);
        send_byte(8'h10, 1);
        do_reset();
        @(negedge clk);
        check("midreset_x", 32'(x_pos), 32'd160);
        e0 = err_cnt;
`ifdef PS2_MOUSE_SYNC_CHECK_EN
        send_byte(8'h00, 1);
        run_packet(8'h08, 8'h01, 8'h00, 1, 10'd161, 9'd120, 3'b000, 1'b0);
        check("sync_error_pulses", 32'(err_cnt - e0), 32'd1);
`else
        run_packet(8'h00, 8'h01, 8'h00, 1, 10'd161, 9'd120, 3'b000, 1'b0);
        check("sync_error_pulses", 32'(err_cnt - e0), 32'd0);
`endif
        check("final_x", 32'(x_pos), 32'd161);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_packet_decoder.md
PS2_MOUSE_PACKET_DECODER -- requirements
Module: ps2_mouse_packet_decoder

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, horizontal pixel count (x range 0..SCREEN_W-1).
REQ-002 SHALL have parameter SCREEN_H, default 240, vertical pixel count (y range 0..SCREEN_H-1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum clk cycles allowed between bytes of one packet.
REQ-004 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port received_data  input  8  byte from the PS/2 data-in stage.
REQ-007 SHALL have port received_data_en  input  1  byte-valid from the PS/2 data-in stage; may stay high for more than one cycle per byte.
REQ-008 SHALL have port clear_position  input  1  synchronous recenter request.
REQ-009 SHALL have port x_pos  output  10  cursor X.
REQ-010 SHALL have port y_pos  output  9  cursor Y, with 0 at the top of the screen.
REQ-011 SHALL have ports left_button, right_button, middle_button  output  1 each  button levels from the last packet.
REQ-012 SHALL have port mousePressed  output  1  one-cycle pulse on a left-button 0->1 transition between packets.
REQ-013 SHALL have port packet_valid  output  1  one-cycle pulse for each completed packet.
REQ-014 SHALL have port packet_error  output  1  one-cycle pulse on an inter-byte timeout or a sync drop.

Function
REQ-015 SHALL accept a byte only on the 0->1 edge of received_data_en (registered edge detect); a held-high level SHALL count as one byte.
REQ-016 SHALL implement the states WAIT_B0, WAIT_B1, WAIT_B2 and UPDATE.
REQ-017 SHALL make these transitions on an accepted byte: WAIT_B0->WAIT_B1, WAIT_B1->WAIT_B2, WAIT_B2->UPDATE.
REQ-018 SHALL leave UPDATE after one cycle, going to WAIT_B0, or to WAIT_B1 if a byte is accepted in that cycle (that byte is byte 0).
REQ-019 SHALL latch byte 0 in WAIT_B0, byte 1 in WAIT_B1 and byte 2 in WAIT_B2.
REQ-020 SHALL form dx as the 9-bit signed value {b0[4], b1} and dy as the 9-bit signed value {b0[5], b2}.
REQ-021 SHALL force dx to 0 when b0[6] (X overflow) is 1, and force dy to 0 when b0[7] (Y overflow) is 1.
REQ-022 SHALL compute new_x = x_pos + dx and new_y = y_pos - dy in 12-bit signed arithmetic (PS/2 +Y means up).
REQ-023 SHALL clamp new_x to 0..SCREEN_W-1 and new_y to 0..SCREEN_H-1.
REQ-024 SHALL register x_pos, y_pos, the button outputs (left=b0[0], right=b0[1], middle=b0[2]), packet_valid and mousePressed on the edge that ends UPDATE.
REQ-025 SHALL therefore make all outputs of a packet visible 2 clk cycles after the edge that accepts byte 2.
REQ-026 SHALL clear its timeout counter on each accepted byte and increment it only in WAIT_B1 and WAIT_B2.
REQ-027 SHALL, when the timeout counter reaches TIMEOUT_CYCLES, go to WAIT_B0, pulse packet_error and leave all position and button outputs unchanged.
REQ-028 SHALL, on clear_position=1, set x_pos=SCREEN_W/2 and y_pos=SCREEN_H/2 on the next edge.
REQ-029 SHALL let clear_position override a position update in the same cycle, while button outputs and packet_valid still update.
REQ-030 SHALL not use clear_position to alter packet framing state.

Reset
REQ-031 SHALL, while reset=0, asynchronously force state=WAIT_B0, x_pos=SCREEN_W/2 (160), y_pos=SCREEN_H/2 (120), all buttons=0, and mousePressed, packet_valid, packet_error, timeout counter and edge-detect register=0.
REQ-032 SHALL discard any partial packet when reset is asserted mid-packet, and treat the first byte accepted after release as byte 0.

Configuration
REQ-033 SHALL, with macro PS2_MOUSE_SYNC_CHECK_EN defined, reject a byte in WAIT_B0 whose bit 3 is 0: state stays WAIT_B0 and packet_error pulses.
REQ-034 SHALL, without PS2_MOUSE_SYNC_CHECK_EN, accept any byte as byte 0 and never raise packet_error for sync.

Structure
REQ-035 SHALL take from shared package ps2_mouse_pkg: the state enum, the b0 bit-position constants (buttons 0-2, sync 3, sign 4/5, overflow 6/7) and the default screen constants.
REQ-036 SHALL instantiate sub-module ps2_mouse_axis_clamp twice (X and Y), each performing signed add with saturation to 0..LIMIT-1.

Verification
REQ-037 SHALL be tested with: bytes 08,10,05 -> x_pos=176, y_pos=115, packet_valid pulse, buttons 000.
REQ-038 SHALL be tested with: bytes 19,C0,00 (dx=-64) repeated 3 times from reset -> x_pos 96, 32, then clamped 0.
REQ-039 SHALL be tested with: bytes 09,00,00 after 08,00,00 -> left_button=1, single mousePressed pulse; a repeat 09,00,00 gives no pulse.
REQ-040 SHALL be tested with: bytes 08,10 then TIMEOUT_CYCLES idle -> packet_error pulse, outputs unchanged; next 08,01,01 decodes as a fresh packet.
REQ-041 SHALL be tested with: PS2_MOUSE_SYNC_CHECK_EN defined, bytes 00 then 08,01,00 -> one packet_error, x_pos=161.
REQ-042 SHALL be tested with: received_data_en held high 5 cycles per byte -> each byte counted once; clear_position asserted in UPDATE -> x_pos=160, y_pos=120.
